// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: turns 'W'/'R' framed UART byte commands into single word bus writes/reads and replies over tx.
// Define UART_BUS_BRIDGE_TIMEOUT_EN to answer a read with NAK when no response arrives within TIMEOUT_CYCLES.
module uart_bus_bridge #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rstB,
    input  logic [7:0]      rxData,
    input  logic            rxValid,
    output logic [7:0]      txData,
    output logic            txValid,
    input  logic            txReady,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] wrData,
    output logic            wrEn,
    output logic            rdEn,
    output logic [3:0]      RamMode,
    input  logic [XLEN-1:0] dataBusIn,
    input  logic            dataBusInEn,
    output logic            busHold
);
    localparam logic [7:0] OP_WR = 8'h57, OP_RD = 8'h52, ACK = 8'h06, NAK = 8'h15;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_WR, BUS_RD, WAIT_RD, RESP} state_t;
    state_t state, stateNext;
    logic [1:0] cnt, respIdx;
    logic isWrite, respLong, lastByte, timeoutHit, readCapture;
    logic [31:0] respBuf;
    logic [XLEN-1:0] addrQ, wrDataQ;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] toCnt;
    assign timeoutHit = toCnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        toCnt <= (!rstB || state != WAIT_RD || dataBusInEn || timeoutHit) ? '0 : toCnt + 1'b1;
`else
    assign timeoutHit = 1'b0;
`endif
    assign readCapture = state == WAIT_RD && dataBusInEn;
    assign lastByte = !respLong || respIdx == 2'd3;
    assign txValid = state == RESP;
    assign txData = respBuf[{respIdx, 3'b000} +: 8];
    assign wrEn = state == BUS_WR;
    assign rdEn = state == BUS_RD;
    assign busHold = state inside {BUS_WR, BUS_RD, WAIT_RD};
    assign addr = addrQ;
    assign wrData = wrDataQ;
    assign RamMode = 4'b0010;
    always_ff @(posedge clk) state <= rstB ? stateNext : IDLE;
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (rxValid) stateNext = (rxData == OP_WR || rxData == OP_RD) ? ADDR : RESP;
            ADDR:    if (rxValid && cnt == 2'd3) stateNext = isWrite ? DATA : BUS_RD;
            DATA:    if (rxValid && cnt == 2'd3) stateNext = BUS_WR;
            BUS_WR:  stateNext = RESP;
            BUS_RD:  stateNext = WAIT_RD;
            WAIT_RD: if (dataBusInEn || timeoutHit) stateNext = RESP;
            RESP:    if (txReady && lastByte) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstB) begin
            cnt      <= '0;
            respIdx  <= '0;
            isWrite  <= 1'b0;
            respLong <= 1'b0;
            respBuf  <= '0;
            addrQ    <= '0;
            wrDataQ  <= '0;
        end else begin
            if (rxValid && (state == ADDR || state == DATA)) cnt <= cnt + 1'b1;
            if (rxValid && state == ADDR) addrQ[{cnt, 3'b000} +: 8] <= rxData;
            if (rxValid && state == DATA) wrDataQ[{cnt, 3'b000} +: 8] <= rxData;
            if (rxValid && state == IDLE) begin
                isWrite <= rxData == OP_WR;
                cnt     <= '0;
            end
            // Only a captured read yields a 4-byte reply; ACK and NAK are single bytes.
            if (stateNext == RESP && state != RESP) begin
                respIdx  <= '0;
                respLong <= readCapture;
                respBuf  <= readCapture ? dataBusIn[31:0] : {24'h0, state == BUS_WR ? ACK : NAK};
            end else if (txValid && txReady) begin
                respIdx <= respIdx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: random and directed framed commands checked against a transaction-level model
// (expected bus operations, expected tx bytes, response latency) every cycle.
module tb_uart_bus_bridge;
    localparam int XLEN = 32, T = 8;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 0, rstB = 0, rxValid = 0, txReady = 0, dataBusInEn = 0;
    logic txValid, wrEn, rdEn, busHold;
    logic [7:0] rxData = 0, txData;
    logic [XLEN-1:0] addr, wrData, dataBusIn = 0;
    logic [3:0] RamMode;

    uart_bus_bridge #(.XLEN(XLEN), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rstB(rstB), .rxData(rxData), .rxValid(rxValid),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .addr(addr), .wrData(wrData), .wrEn(wrEn), .rdEn(rdEn), .RamMode(RamMode),
        .dataBusIn(dataBusIn), .dataBusInEn(dataBusInEn), .busHold(busHold)
    );

    always #5 clk = ~clk;

    typedef struct {bit isWr; logic [31:0] a; logic [31:0] d;} bus_t;
    bus_t expBus[$];
    logic [7:0] expTx[$], txLog[$];
    int total = 0, bad = 0, cyc = 0;
    int expStrobeCyc = 0, expRespDelay = 0, rdCyc = 0, rspLat = 0, holdCycles = 0, waitCnt = 0;
    bit rdPending = 0, rdTimingPending = 0, forceLow = 0, randReady = 0, noise = 1;
    logic prevValid = 0, prevReady = 0;
    logic [7:0] prevData = 0;
    logic [31:0] lastWrAddr = 0, lastWrData = 0, stickAddr = 0, stickData = 0, rspData = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] packLog();
        logic [31:0] v = 0;
        foreach (txLog[i]) v = v | (32'(txLog[i]) << (8 * i));
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model checker: every cycle out of reset, outputs are set against the transaction expectations.
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (!rstB) begin
                prevValid = 0;
                rdPending = 0;
                rdTimingPending = 0;
                stickAddr = 0;
                stickData = 0;
            end else begin
                chk("busHold", busHold, wrEn | rdEn | rdPending);
                holdCycles += int'(busHold);
                if (wrEn || rdEn) begin
                    chk("one_strobe", wrEn & rdEn, 0);
                    if (expBus.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: wrEn=%0b rdEn=%0b with no frame pending", wrEn, rdEn);
                    end else begin
                        e = expBus.pop_front();
                        chk("strobe_kind", wrEn, e.isWr);
                        chk("strobe_cycle", cyc, expStrobeCyc);
                        chk("strobe_addr", addr, e.a);
                        chk("RamMode", RamMode, 4'b0010);
                        stickAddr = e.a;
                        stickData = wrData;
                        if (wrEn) begin
                            chk("strobe_wrData", wrData, e.d);
                            lastWrAddr = addr;
                            lastWrData = wrData;
                        end
                    end
                end
                if (rdEn) begin
                    rdPending = 1;
                    waitCnt = 0;
                    rdCyc = cyc;
                    rdTimingPending = 1;
                end else if (rdPending) begin
                    waitCnt++;
                    if (dataBusInEn || (TO_EN && waitCnt == T)) rdPending = 0;
                end
                if (rdTimingPending && txValid) begin
                    chk("resp_latency", cyc - rdCyc, expRespDelay);
                    rdTimingPending = 0;
                end
                if (txValid) begin
                    chk("addr_stable", addr, stickAddr);
                    chk("wrData_stable", wrData, stickData);
                end
                if (prevValid && !prevReady) begin
                    chk("tx_hold_valid", txValid, 1);
                    chk("tx_hold_data", txData, prevData);
                end
                if (txValid && txReady) begin
                    txLog.push_back(txData);
                    if (expTx.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_tx: byte %0h with nothing queued", txData);
                    end else chk("txData", txData, expTx.pop_front());
                end
                prevValid = txValid;
                prevReady = txReady;
                prevData = txData;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1 txReady = forceLow ? 1'b0 : (randReady ? ($urandom % 3 != 0) : 1'b1);
    end

    // Responder: answers rspLat cycles after rdEn; rspLat of 0 never answers.
    initial forever begin
        @(negedge clk);
        if (rstB && rdEn && rspLat != 0) begin
            repeat (rspLat) @(posedge clk);
            #1 dataBusInEn = 1;
            dataBusIn = rspData;
            @(posedge clk);
            #1 dataBusInEn = 0;
            dataBusIn = $urandom;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxData = b;
        rxValid = 1;
        step();
        rxValid = 0;
        rxData = 8'($urandom);
        repeat ($urandom % 3) step();
    endtask

    task automatic sendWrite(input logic [31:0] a, input logic [31:0] d);
        expBus.push_back('{1'b1, a, d});
        expTx.push_back(8'h06);
        sendByte(8'h57);
        for (int i = 0; i < 4; i++) sendByte(a[8*i +: 8]);
        for (int i = 0; i < 3; i++) sendByte(d[8*i +: 8]);
        expStrobeCyc = cyc + 1;
        sendByte(d[31:24]);
    endtask

    task automatic sendRead(input logic [31:0] a, input logic [31:0] d, input int lat);
        bit timedOut = TO_EN && (lat == 0 || lat > T);
        expBus.push_back('{1'b0, a, 32'h0});
        rspLat = lat;
        rspData = d;
        expRespDelay = timedOut ? T + 1 : lat + 1;
        if (timedOut) expTx.push_back(8'h15);
        else for (int i = 0; i < 4; i++) expTx.push_back(d[8*i +: 8]);
        sendByte(8'h52);
        for (int i = 0; i < 3; i++) sendByte(a[8*i +: 8]);
        expStrobeCyc = cyc + 1;
        sendByte(a[31:24]);
    endtask

    task automatic sendBad(input logic [7:0] b);
        expTx.push_back(8'h15);
        sendByte(b);
    endtask

    // Bytes sent while a transaction is still owed must be ignored by the bridge.
    task automatic waitDone();
        int n = 0;
        while ((expTx.size() != 0 || expBus.size() != 0) && n < 300) begin
            rxValid = noise && ($urandom % 3 == 0);
            rxData = 8'($urandom);
            step();
            n++;
        end
        rxValid = 0;
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL done_wait: %0d tx bytes and %0d strobes still owed after %0d cycles", expTx.size(), expBus.size(), n);
            expTx.delete();
            expBus.delete();
        end
        step();
    endtask

    task automatic waitTxValid(input string name);
        int n = 0;
        while (!txValid && n < 60) begin
            step();
            n++;
        end
        if (!txValid) begin
            total++;
            bad++;
            $display("FAIL %s: txValid never rose within %0d cycles", name, n);
        end
    endtask

    task automatic pulseReset();
        rstB = 0;
        step();
        rstB = 1;
        expTx.delete();
        expBus.delete();
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) step();
        chk("rst_txValid", txValid, 0);
        chk("rst_wrEn", wrEn, 0);
        chk("rst_rdEn", rdEn, 0);
        chk("rst_busHold", busHold, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wrData", wrData, 0);
        chk("rst_txData", txData, 0);
        chk("rst_RamMode", RamMode, 4'b0010);
        rstB = 1;
        step();

        txLog.delete();
        holdCycles = 0;
        sendWrite(32'h10, 32'hDEADBEEF);
        waitDone();
        chk("w_addr", lastWrAddr, 32'h10);
        chk("w_data", lastWrData, 32'hDEADBEEF);
        chk("w_tx", packLog(), 32'h06);
        chk("w_len", txLog.size(), 1);
        chk("w_hold", holdCycles, 1);

        txLog.delete();
        holdCycles = 0;
        sendRead(32'h10, 32'h12345678, 2);
        waitDone();
        chk("r_tx", packLog(), 32'h12345678);
        chk("r_len", txLog.size(), 4);
        chk("r_hold", holdCycles, 3);

        txLog.delete();
        holdCycles = 0;
        sendBad(8'h41);
        waitDone();
        chk("bad_tx", packLog(), 32'h15);
        chk("bad_len", txLog.size(), 1);
        chk("bad_hold", holdCycles, 0);

        txLog.delete();
        forceLow = 1;
        sendRead(32'h200, 32'hA1B2C3D4, 3);
        waitTxValid("bp_wait");
        repeat (10) step();
        chk("bp_valid", txValid, 1);
        chk("bp_data", txData, 8'hD4);
        forceLow = 0;
        waitDone();
        chk("bp_tx", packLog(), 32'hA1B2C3D4);

        txLog.delete();
        sendRead(32'h304, 32'hCAFEF00D, T);
        waitDone();
        chk("edge_tx", packLog(), 32'hCAFEF00D);
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
        txLog.delete();
        sendRead(32'h300, 32'h0BADF00D, 0);
        waitDone();
        chk("to_nak", packLog(), 32'h15);
        chk("to_len", txLog.size(), 1);
        txLog.delete();
        sendRead(32'h308, 32'h600DF00D, T + 1);
        waitDone();
        chk("to_late", packLog(), 32'h15);
        repeat (4) step();
`endif

        sendByte(8'h57);
        sendByte(8'h10);
        sendByte(8'h00);
        pulseReset();
        repeat (3) step();
        chk("mid_addr", addr, 0);
        chk("mid_wrData", wrData, 0);
        chk("mid_busHold", busHold, 0);
        chk("mid_txValid", txValid, 0);
        txLog.delete();
        sendWrite(32'h44, 32'h01020304);
        waitDone();
        chk("mid_w_tx", packLog(), 32'h06);
        chk("mid_w_data", lastWrData, 32'h01020304);

        forceLow = 1;
        sendRead(32'h500, 32'h55667788, 1);
        waitTxValid("rr_wait");
        pulseReset();
        forceLow = 0;
        repeat (5) step();
        chk("rr_txValid", txValid, 0);

        randReady = 1;
        for (int k = 0; k < 60; k++) begin
            case ($urandom % 3)
                0: sendWrite($urandom, $urandom);
                1: sendRead($urandom, $urandom, $urandom_range(1, 6));
                default: begin
                    b = 8'($urandom);
                    while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                    sendBad(b);
                end
            endcase
            waitDone();
        end
        randReady = 0;
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data-bus and address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the read-response timeout in clk cycles.
REQ-003 Ports (name, direction, width, meaning):
- clk, input, 1: sole clock; all logic on the rising edge.
- rstB, input, 1: synchronous, active-low reset.
- rxData, input, 8: received byte from the UART byte stream.
- rxValid, input, 1: one-cycle strobe; rxData is valid this cycle.
- txData, output, 8: byte to transmit.
- txValid, output, 1: txData is valid; held until accepted.
- txReady, input, 1: transmitter accepts the byte when txValid and txReady are both 1.
- addr, output, XLEN: bus address.
- wrData, output, XLEN: bus write data.
- wrEn, output, 1: one-cycle bus write strobe.
- rdEn, output, 1: one-cycle bus read strobe.
- RamMode, output, 4: {byte, half, word, unsigned}; fixed at 4'b0010 (word).
- dataBusIn, input, XLEN: read data returned by the responder.
- dataBusInEn, input, 1: dataBusIn is valid this cycle.
- busHold, output, 1: bridge owns the bus; the core arbiter stalls while this is 1.

Function
REQ-004 The bridge SHALL act as a bus initiator driven by framed commands on the rx byte stream.
REQ-005 Frame formats SHALL be:
- Write: 0x57 ('W'), then 4 address bytes LSB first, then 4 data bytes LSB first.
- Read: 0x52 ('R'), then 4 address bytes LSB first.
REQ-006 FSM states SHALL be IDLE, ADDR, DATA, BUS_WR, BUS_RD, WAIT_RD, RESP.
REQ-007 In IDLE, rxValid with 0x57 or 0x52 SHALL latch the opcode and enter ADDR with the byte counter at 0.
REQ-008 In IDLE, any other byte SHALL queue NAK 0x15 and enter RESP.
REQ-009 In ADDR, each rxValid SHALL shift rxData into addr byte[counter] and increment the counter.
REQ-010 After the 4th address byte, a write SHALL enter DATA and a read SHALL enter BUS_RD.
REQ-011 In DATA, each rxValid SHALL fill wrData the same way; the 4th data byte SHALL enter BUS_WR.
REQ-012 BUS_WR SHALL assert wrEn for exactly one cycle (the cycle after the last data byte), queue ACK 0x06, then enter RESP.
REQ-013 BUS_RD SHALL assert rdEn for exactly one cycle, then enter WAIT_RD.
REQ-014 In WAIT_RD, the first cycle with dataBusInEn=1 SHALL capture dataBusIn into a 4-byte response buffer and enter RESP.
REQ-015 In RESP, the bridge SHALL present queued bytes in order, LSB first for read data.
REQ-016 txData SHALL advance only on a cycle where txValid=1 and txReady=1.
REQ-017 After the last byte is accepted, the FSM SHALL return to IDLE.
REQ-018 Bytes arriving on rxValid while in BUS_WR, BUS_RD, WAIT_RD or RESP SHALL be discarded.
REQ-019 busHold SHALL be 1 in BUS_WR, BUS_RD and WAIT_RD and 0 in all other states.
REQ-020 wrEn and rdEn SHALL never be 1 in the same cycle.
REQ-021 addr and wrData SHALL stay stable from the strobe cycle until the FSM returns to IDLE.
REQ-022 The byte counter SHALL be 2 bits and wrap 3->0 on a state change.

Reset
REQ-023 While rstB=0 at a clk edge, the FSM SHALL enter IDLE.
REQ-024 Reset values SHALL be: txValid=0, wrEn=0, rdEn=0, busHold=0, addr=0, wrData=0, txData=0, counter=0, timeout counter=0.
REQ-025 Reset asserted mid-frame or mid-response SHALL abandon the transaction with no bus strobe and no further tx bytes.

Configuration
REQ-026 With macro UART_BUS_BRIDGE_TIMEOUT_EN defined:
- WAIT_RD SHALL count cycles.
- If TIMEOUT_CYCLES elapse without dataBusInEn, the bridge SHALL queue the single byte NAK 0x15, deassert busHold and enter RESP.
- A dataBusInEn arriving on the same cycle as the terminal count SHALL win.
REQ-027 Without UART_BUS_BRIDGE_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-028 Write: rx 57 10 00 00 00 EF BE AD DE -> one wrEn cycle with addr=0x10, wrData=0xDEADBEEF, RamMode=0010; then tx 06.
REQ-029 Read: rx 52 10 00 00 00; responder returns 0x12345678 two cycles after rdEn -> tx 78 56 34 12; busHold=1 only from rdEn through capture.
REQ-030 Bad opcode: rx 41 -> tx 15; no wrEn or rdEn; FSM back in IDLE.
REQ-031 Backpressure: txReady held at 0 for 10 cycles during a read response -> txData/txValid stable; all 4 bytes delivered in order once txReady=1.
REQ-032 Timeout (macro defined, TIMEOUT_CYCLES=8): read with no dataBusInEn -> tx 15 after 8 cycles; a second case with dataBusInEn on cycle 8 -> data returned, not NAK.
REQ-033 Reset: rstB=0 after 2 address bytes -> no strobe; a subsequent full write frame completes normally.
